bus_master_port: RTL
====================

Name: bus_master_port

Overview:
- Initiator end of the single-wire serial bus. It accepts one parallel read or write request from the local module and serialises start bit, 2-bit slave ID and address onto data_bus_serial.
- It then collects the slave's acknowledges and either shifts out write data or waits for and deserialises read data.
- It owns bus_util and rd_wrt for the whole transaction, and returns a one-cycle response with an error flag.

Parameters:
- ADDRESS_WIDTH, 15, address bits sent per transaction
- DATA_WIDTH, 8, data bits per transfer
- ACK_TIMEOUT, 32, max cycles waited for any slave acknowledge
- READ_TIMEOUT, 256, max cycles waited for the slave to begin returning read data

Ports:
- clk  in  1  clock; all logic on posedge
- rstn  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk
- req_valid  in  1  request strobe
- req_ready  out  1  high in IDLE only; transfer occurs on req_valid & req_ready
- req_rd_wrt  in  1  1 = write, 0 = read
- req_slave_id  in  2  target slave ID
- req_addr  in  ADDRESS_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle pulse at transaction end
- resp_err  out  1  valid with resp_valid; 1 = timeout
- resp_rdata  out  DATA_WIDTH  read data; valid with resp_valid on a successful read
- bus_util  out  1  high from the START cycle through the last bus cycle
- rd_wrt  out  1  registered copy of req_rd_wrt, held for the whole transaction
- data_bus_serial  inout  1  serial line; master drives 0/1 or Z; line is pulled high, Z/1 both read as 1
- slave_busy  in  1  open-drain busy line from slaves; sensed only, never driven

Behaviour:
- Reset: state IDLE, data_bus_serial Z, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, bus_util 0, rd_wrt 0, all counters 0. Reset mid-transaction aborts the transaction immediately: line released next edge, no response emitted.
- Handshake: request fields are latched on the accept edge. req_ready deasserts the next cycle and reasserts on the cycle after resp_valid.
- States and transitions (one bus bit per clk):
  - IDLE -> START on accept.
  - START: drive 0 for 1 cycle; bus_util 1.
  - SID: drive id[1] then id[0], 2 cycles.
  - ADDR_TX: ADDRESS_WIDTH cycles, MSB first.
  - ADDR_ACK_WAIT: line released (Z). Success requires the line sampled 0 on two consecutive cycles. A single 0 followed by 1 restarts the pair search. Timer starts at entry; after ACK_TIMEOUT cycles without success -> ERR.
  - On address ack: write -> DATA_TX; read -> RD_WAIT_BUSY.
  - DATA_TX: DATA_WIDTH cycles, MSB first -> DATA_ACK_WAIT.
  - DATA_ACK_WAIT: released. Success requires a 0 followed on the next cycle by a 1. Same timeout rule. Success -> DONE.
  - RD_WAIT_BUSY: wait for slave_busy 0 (slave fetching memory), then for slave_busy 1 again -> RD_START.
  - RD_START: wait for line sampled 0 (slave start bit) -> RD_RX. One READ_TIMEOUT timer covers RD_WAIT_BUSY and RD_START combined.
  - RD_RX: sample DATA_WIDTH bits, MSB first, on the DATA_WIDTH cycles following the start bit -> DONE.
  - DONE: resp_valid 1, resp_err 0, resp_rdata updated only on reads -> IDLE.
  - ERR: resp_valid 1, resp_err 1, resp_rdata unchanged -> IDLE.
- bus_util falls on the DONE/ERR cycle. The line is Z in every state except START/SID/ADDR_TX/DATA_TX.
- Timer: width $clog2 of max(ACK_TIMEOUT, READ_TIMEOUT)+1. Cleared on every state entry. Timeout fires when count == limit-1 without success.
- Simultaneous events: a success condition seen on the same cycle as timeout expiry counts as success.
- A request presented while busy is ignored (not queued).
- Bit counter: $clog2(max(ADDRESS_WIDTH, DATA_WIDTH)) bits; reloads to width-1 on entry and counts down; the state exits when it reaches 0.

Decomposition:
- Shared package bus_pkg: state encoding localparams, SLAVE_ID_WIDTH = 2, START_BIT = 1'b0, ack pattern constants (ADDR_ACK = 2'b00, DATA_ACK = 2'b01).
- One sub-module, bus_master_shifter: a loadable MSB-first shift register plus down-counter with modes tx/rx/idle, done pulse and serial in/out. The FSM, tristate and timers stay in bus_master_port.

Test Plan:
- Write id=2'b01, addr=15'h1234, wdata=8'hA5; slave model acks 00 at cycle 3 of the wait and returns 0,1 after data. Required: line shows 0,0,1, address MSB-first, then 10100101; resp_valid=1, resp_err=0; bus_util high throughout.
- Read id=2'b10, addr=15'h0007; slave acks 00, drops slave_busy for 5 cycles, raises it, sends 0 then 8'h3C. Required: resp_rdata=8'h3C, resp_err=0; rd_wrt=0 throughout.
- No slave responds to the address. Required: resp_valid with resp_err=1 exactly ACK_TIMEOUT cycles after ADDR_ACK_WAIT entry; line Z; req_ready back to 1.
- Slave sends 0,1,0,0 during the address ack wait. Required: the first isolated 0 is ignored and the ack is accepted on the second 0 of the pair.
- Reset asserted mid DATA_TX. Required: next cycle state IDLE, line Z, bus_util 0, no resp_valid; a new request is accepted afterwards.
- req_valid held high across completion. Required: a second transaction starts one cycle after resp_valid, and req_valid while busy is not accepted.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the single-wire serial bus: FSM states, shifter modes,
// framing bits and acknowledge patterns.
package bus_pkg;

  localparam int          SLAVE_ID_WIDTH = 2;
  localparam logic        START_BIT      = 1'b0;
  localparam logic [1:0]  ADDR_ACK       = 2'b00;
  localparam logic [1:0]  DATA_ACK       = 2'b01;

  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_IDLE          = 4'd0;
  localparam logic [STATE_W-1:0] ST_START         = 4'd1;
  localparam logic [STATE_W-1:0] ST_SID           = 4'd2;
  localparam logic [STATE_W-1:0] ST_ADDR_TX       = 4'd3;
  localparam logic [STATE_W-1:0] ST_ADDR_ACK_WAIT = 4'd4;
  localparam logic [STATE_W-1:0] ST_DATA_TX       = 4'd5;
  localparam logic [STATE_W-1:0] ST_DATA_ACK_WAIT = 4'd6;
  localparam logic [STATE_W-1:0] ST_RD_WAIT_BUSY  = 4'd7;
  localparam logic [STATE_W-1:0] ST_RD_START      = 4'd8;
  localparam logic [STATE_W-1:0] ST_RD_RX         = 4'd9;
  localparam logic [STATE_W-1:0] ST_DONE          = 4'd10;
  localparam logic [STATE_W-1:0] ST_ERR           = 4'd11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE          = ST_IDLE,
    S_START         = ST_START,
    S_SID           = ST_SID,
    S_ADDR_TX       = ST_ADDR_TX,
    S_ADDR_ACK_WAIT = ST_ADDR_ACK_WAIT,
    S_DATA_TX       = ST_DATA_TX,
    S_DATA_ACK_WAIT = ST_DATA_ACK_WAIT,
    S_RD_WAIT_BUSY  = ST_RD_WAIT_BUSY,
    S_RD_START      = ST_RD_START,
    S_RD_RX         = ST_RD_RX,
    S_DONE          = ST_DONE,
    S_ERR           = ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    SH_IDLE = 2'd0,
    SH_TX   = 2'd1,
    SH_RX   = 2'd2
  } sh_mode_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_master_shifter.sv
// MSB-first shift register with a down-counter; load has priority over the
// tx/rx shift so a state can hand off to the next field on its last bit.
module bus_master_shifter
  import bus_pkg::*;
#(
  parameter int SW = 15,
  parameter int CW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [SW-1:0] load_data,
  input  logic [CW-1:0] load_cnt,
  input  sh_mode_e      mode,
  input  logic          serial_in,
  output logic          serial_out,
  output logic          done,
  output logic [DW-1:0] rx_data
);

  logic [SW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = load_cnt;
    end else begin
      case (mode)
        SH_TX: begin
          shreg_d = {shreg_q[SW-2:0], 1'b0};
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        SH_RX: begin
          shreg_d = {shreg_q[SW-2:0], serial_in};
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serial_out = shreg_q[SW-1];
  assign done       = (mode != SH_IDLE) && (cnt_q == '0);
  // Includes the bit being sampled this cycle, so the word is complete on the last bit.
  assign rx_data    = shreg_d[DW-1:0];

endmodule

// File: rtl/bus_master_port.sv
// Initiator of the single-wire serial bus: frames start/ID/address, collects
// acks, then shifts write data out or receives read data, one bit per clock.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int ACK_TIMEOUT   = 32,
  parameter int READ_TIMEOUT  = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rd_wrt,
  input  logic [SLAVE_ID_WIDTH-1:0] req_slave_id,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      bus_util,
  output logic                      rd_wrt,
  inout  wire                       data_bus_serial,
  input  logic                      slave_busy
);

  localparam int SW = max2(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int CW = (SW > 1) ? $clog2(SW) : 1;
  localparam int TW = $clog2(max2(ACK_TIMEOUT, READ_TIMEOUT) + 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] READ_LAST = TW'(READ_TIMEOUT - 1);

  state_e                      state_q, state_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic                        prev_vld_q, prev_vld_d;
  logic                        prev_bit_q, prev_bit_d;
  logic                        busy_low_q, busy_low_d;
  logic [SLAVE_ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        rd_wrt_q, rd_wrt_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

  logic                        sh_load;
  logic [SW-1:0]               sh_ld_data;
  logic [CW-1:0]               sh_ld_cnt;
  sh_mode_e                    sh_mode;
  logic                        sh_out, sh_done;
  logic [DATA_WIDTH-1:0]       sh_rx;

  logic                        drv_en, drv_bit;
  logic                        line_in;
  logic [1:0]                  ack_pair;

  assign line_in  = data_bus_serial;
  assign ack_pair = {prev_bit_q, line_in};

  bus_master_shifter #(
    .SW (SW),
    .CW (CW),
    .DW (DATA_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .rstn       (rstn),
    .load       (sh_load),
    .load_data  (sh_ld_data),
    .load_cnt   (sh_ld_cnt),
    .mode       (sh_mode),
    .serial_in  (line_in),
    .serial_out (sh_out),
    .done       (sh_done),
    .rx_data    (sh_rx)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    prev_vld_d = prev_vld_q;
    prev_bit_d = prev_bit_q;
    busy_low_d = busy_low_q;
    id_d       = id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_wrt_d   = rd_wrt_q;
    rdata_d    = rdata_q;
    sh_load    = 1'b0;
    sh_ld_data = '0;
    sh_ld_cnt  = '0;
    sh_mode    = SH_IDLE;
    drv_en     = 1'b0;
    drv_bit    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_START;
          id_d     = req_slave_id;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_wrt_d = req_rd_wrt;
        end
      end
      S_START: begin
        drv_en     = 1'b1;
        drv_bit    = START_BIT;
        state_d    = S_SID;
        sh_load    = 1'b1;
        sh_ld_data = SW'(id_q) << (SW - SLAVE_ID_WIDTH);
        sh_ld_cnt  = CW'(SLAVE_ID_WIDTH - 1);
      end
      S_SID: begin
        drv_en  = 1'b1;
        drv_bit = sh_out;
        sh_mode = SH_TX;
        if (sh_done) begin
          state_d    = S_ADDR_TX;
          sh_load    = 1'b1;
          sh_ld_data = SW'(addr_q) << (SW - ADDRESS_WIDTH);
          sh_ld_cnt  = CW'(ADDRESS_WIDTH - 1);
        end
      end
      S_ADDR_TX: begin
        drv_en  = 1'b1;
        drv_bit = sh_out;
        sh_mode = SH_TX;
        if (sh_done) state_d = S_ADDR_ACK_WAIT;
      end
      // Ack checks take priority over the timeout on the expiry cycle.
      S_ADDR_ACK_WAIT: begin
        timer_d    = timer_q + TW'(1);
        prev_vld_d = 1'b1;
        prev_bit_d = line_in;
        if (prev_vld_q && ack_pair == ADDR_ACK) begin
          if (rd_wrt_q) begin
            state_d    = S_DATA_TX;
            sh_load    = 1'b1;
            sh_ld_data = SW'(wdata_q) << (SW - DATA_WIDTH);
            sh_ld_cnt  = CW'(DATA_WIDTH - 1);
          end else begin
            state_d = S_RD_WAIT_BUSY;
          end
        end else if (timer_q == ACK_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DATA_TX: begin
        drv_en  = 1'b1;
        drv_bit = sh_out;
        sh_mode = SH_TX;
        if (sh_done) state_d = S_DATA_ACK_WAIT;
      end
      S_DATA_ACK_WAIT: begin
        timer_d    = timer_q + TW'(1);
        prev_vld_d = 1'b1;
        prev_bit_d = line_in;
        if (prev_vld_q && ack_pair == DATA_ACK) state_d = S_DONE;
        else if (timer_q == ACK_LAST)            state_d = S_ERR;
      end
      S_RD_WAIT_BUSY: begin
        timer_d = timer_q + TW'(1);
        if (!slave_busy) busy_low_d = 1'b1;
        if (busy_low_q && slave_busy) state_d = S_RD_START;
        else if (timer_q == READ_LAST) state_d = S_ERR;
      end
      S_RD_START: begin
        timer_d = timer_q + TW'(1);
        if (line_in == START_BIT) begin
          state_d   = S_RD_RX;
          sh_load   = 1'b1;
          sh_ld_cnt = CW'(DATA_WIDTH - 1);
        end else if (timer_q == READ_LAST) begin
          state_d = S_ERR;
        end
      end
      S_RD_RX: begin
        sh_mode = SH_RX;
        if (sh_done) begin
          state_d = S_DONE;
          rdata_d = sh_rx;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The read timer spans both busy-wait and start-bit-wait.
    if (state_d != state_q) begin
      prev_vld_d = 1'b0;
      busy_low_d = 1'b0;
      if (!(state_q == S_RD_WAIT_BUSY && state_d == S_RD_START)) timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      prev_vld_q <= 1'b0;
      prev_bit_q <= 1'b1;
      busy_low_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_wrt_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      prev_vld_q <= prev_vld_d;
      prev_bit_q <= prev_bit_d;
      busy_low_q <= busy_low_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_wrt_q   <= rd_wrt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_DONE) || (state_q == S_ERR);
  assign resp_err        = (state_q == S_ERR);
  assign resp_rdata      = rdata_q;
  assign bus_util        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign rd_wrt          = rd_wrt_q;
  assign data_bus_serial = drv_en ? drv_bit : 1'bz;

endmodule
